// File: rtl/ssc_display_arbiter.sv
// Round-robin owner of one eight-digit seven-segment display shared by two
// requesters; holds each grant for a minimum time and registers what is shown.
module ssc_display_arbiter #(
    parameter int HOLD_CYCLES = 50000000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic [7:0]  dp0,
    input  logic        req1,
    input  logic [31:0] data1,
    input  logic [7:0]  dp1,
    output logic [1:0]  grant,
    output logic [31:0] disp_data,
    output logic [7:0]  disp_digits,
    output logic [7:0]  disp_points
);

    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] hold_reg, hold_next;
    logic          ptr_reg, ptr_next;
    logic [1:0]    grant_reg, grant_next;
    logic [31:0]   disp_data_reg, disp_data_next;
    logic [7:0]    disp_digits_reg, disp_digits_next;
    logic [7:0]    disp_points_reg, disp_points_next;

    logic [31:0]   sel_data;
    logic [7:0]    sel_points;
    logic [7:0]    nibble_nz;
    logic [7:0]    sel_mask;

    // Digit k is lit when it or any more significant nibble is nonzero;
    // digit 0 is forced on so a zero value still shows a single 0.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nibble
            assign nibble_nz[gi] = |sel_data[4*gi +: 4];
            assign sel_mask[gi]  = |nibble_nz[7:gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        hold_next  = (hold_reg == '0) ? '0 : hold_reg - CW'(1);
        ptr_next   = ptr_reg;
        sel_data   = disp_data_reg;
        sel_points = disp_points_reg;

        case (state_reg)
            IDLE: begin
                if (req0 && (!req1 || !ptr_reg)) begin
                    state_next = OWN0;
                end else if (req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (req0) begin
                    sel_data   = data0;
                    sel_points = dp0;
                end
                if (hold_reg == '0) begin
                    if (req1) begin
                        state_next = OWN1;
                    end else if (!req0) begin
                        state_next = IDLE;
                    end
                end
            end
            OWN1: begin
                if (req1) begin
                    sel_data   = data1;
                    sel_points = dp1;
                end
                if (hold_reg == '0) begin
                    if (req0) begin
                        state_next = OWN0;
                    end else if (!req1) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A fresh grant (from idle or a direct switch) restarts the hold
        // and hands round-robin preference to the other requester.
        if (state_next == OWN0 && state_reg != OWN0) begin
            hold_next  = HOLD_LOAD;
            ptr_next   = 1'b1;
            sel_data   = data0;
            sel_points = dp0;
        end else if (state_next == OWN1 && state_reg != OWN1) begin
            hold_next  = HOLD_LOAD;
            ptr_next   = 1'b0;
            sel_data   = data1;
            sel_points = dp1;
        end

        grant_next = {state_next == OWN1, state_next == OWN0};
        if (state_next == IDLE) begin
            disp_data_next   = '0;
            disp_digits_next = '0;
            disp_points_next = '0;
        end else begin
            disp_data_next   = sel_data;
            disp_digits_next = BLANK_ZEROS ? (sel_mask | 8'h01) : 8'hFF;
            disp_points_next = sel_points;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            hold_reg        <= '0;
            ptr_reg         <= 1'b0;
            grant_reg       <= '0;
            disp_data_reg   <= '0;
            disp_digits_reg <= '0;
            disp_points_reg <= '0;
        end else begin
            state_reg       <= state_next;
            hold_reg        <= hold_next;
            ptr_reg         <= ptr_next;
            grant_reg       <= grant_next;
            disp_data_reg   <= disp_data_next;
            disp_digits_reg <= disp_digits_next;
            disp_points_reg <= disp_points_next;
        end
    end

    assign grant       = grant_reg;
    assign disp_data   = disp_data_reg;
    assign disp_digits = disp_digits_reg;
    assign disp_points = disp_points_reg;

endmodule
